wb_stage: RTL and testbench

Writeback stage of the five-stage pipeline, directly downstream of the memory stage. Selects the writeback value, drives the general-purpose register-file write port, and owns the system registers (rm0–rm7) and the privilege bit. Converts TLB misses, privilege violations and `iret` into a precise pipeline flush and PC redirect through a small exception state machine.

---
 rtl/wb_stage_if.sv | 44 ++++
 rtl/wb_stage.sv | 123 ++++++++++++
 tb/tb_wb_stage.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// Writeback stage bus: memory-stage inputs, GPR write port, system-register
// read port, privilege bit and the flush/redirect controls toward fetch.
interface wb_stage_if;
    logic        en;
    logic        WB_EN;
    logic        MEM_TO_REG;
    logic [31:0] read_data_mem;
    logic [31:0] alu_result;
    logic [4:0]  regD;
    logic        WB_SYS_EN;
    logic        TLB_MISS;
    logic [31:0] PC_TO_REG;
    logic [31:0] ADDRESS_TO_REG;
    logic        injected_nop;
    logic        iret;
    logic [2:0]  sys_raddr;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] sys_rdata;
    logic        supervisor_mode;
    logic        flush;
    logic        pc_redirect;
    logic [31:0] pc_target;

    // Upstream pipeline / register file side.
    modport master (
        output en, WB_EN, MEM_TO_REG, read_data_mem, alu_result, regD,
               WB_SYS_EN, TLB_MISS, PC_TO_REG, ADDRESS_TO_REG,
               injected_nop, iret, sys_raddr,
        input  rf_we, rf_waddr, rf_wdata, sys_rdata, supervisor_mode,
               flush, pc_redirect, pc_target
    );

    // Writeback stage side.
    modport slave (
        input  en, WB_EN, MEM_TO_REG, read_data_mem, alu_result, regD,
               WB_SYS_EN, TLB_MISS, PC_TO_REG, ADDRESS_TO_REG,
               injected_nop, iret, sys_raddr,
        output rf_we, rf_waddr, rf_wdata, sys_rdata, supervisor_mode,
               flush, pc_redirect, pc_target
    );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: selects the writeback value, drives the GPR write port,
// owns rm0-rm7 and the privilege bit, and turns TLB misses, privilege
// violations and iret into a flush followed by a one-cycle PC redirect.
module wb_stage #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_2000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    wb_stage_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        REDIRECT
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rm_q [8];
    logic [31:0] rm_d [8];
    logic        sup_q, sup_d;
    logic [31:0] target_q, target_d;

    logic        valid;
    logic        priv_viol;
    logic [31:0] wb_data;
    logic        rf_we;
    logic        flush;
    logic        pc_redirect;

    assign valid     = bus.en && !bus.injected_nop && (state_q == IDLE);
    assign wb_data   = bus.MEM_TO_REG ? bus.read_data_mem : bus.alu_result;
    assign priv_viol = (bus.WB_SYS_EN || bus.iret) && !sup_q;

    // Commit decision, exception entry and flush/redirect sequencing.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        rm_d        = rm_q;
        sup_d       = sup_q;
        target_d    = target_q;
        rf_we       = 1'b0;
        flush       = 1'b0;
        pc_redirect = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (valid) begin
                    if (bus.TLB_MISS || priv_viol) begin
                        rm_d[0]  = bus.PC_TO_REG;
                        rm_d[1]  = bus.TLB_MISS ? bus.ADDRESS_TO_REG : 32'd0;
                        rm_d[2]  = bus.TLB_MISS ? 32'd1 : 32'd2;
                        sup_d    = 1'b1;
                        target_d = EXC_VECTOR;
                        cnt_d    = FLUSH_LOAD;
                        state_d  = FLUSH;
                    end else if (bus.iret) begin
                        sup_d    = 1'b0;
                        target_d = rm_q[0];
                        cnt_d    = FLUSH_LOAD;
                        state_d  = FLUSH;
                    end else if (bus.WB_SYS_EN) begin
                        rm_d[bus.regD[2:0]] = wb_data;
                    end else begin
                        rf_we = bus.WB_EN && (bus.regD != 5'd0);
                    end
                end
            end
            FLUSH: begin
                flush = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = REDIRECT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            REDIRECT: begin
                flush       = 1'b1;
                pc_redirect = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, system registers, privilege bit and latched redirect target.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            sup_q    <= 1'b1;
            target_q <= 32'd0;
            // NOTE: rm0-rm7 are architectural state with defined reset values, so this small array is reset rather than left as uninitialised storage.
            for (int i = 0; i < 8; i++) begin
                rm_q[i] <= 32'd0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values computed above.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sup_q    <= sup_d;
            target_q <= target_d;
            for (int i = 0; i < 8; i++) begin
                rm_q[i] <= rm_d[i];
            end
        end
    end

    assign bus.rf_we           = rf_we && !reset;
    assign bus.rf_waddr        = bus.regD;
    assign bus.rf_wdata        = wb_data;
    assign bus.sys_rdata       = rm_q[bus.sys_raddr];
    assign bus.supervisor_mode = sup_q;
    assign bus.flush           = flush;
    assign bus.pc_redirect     = pc_redirect;
    assign bus.pc_target       = pc_redirect ? target_q : 32'd0;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios followed by random traffic, all
// checked cycle by cycle against an architectural model of the stage.
module tb_wb_stage;

    localparam logic [31:0] EXC_VEC = 32'h0000_2000;
    localparam int          FC      = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_stage_if bus();

    wb_stage #(
        .EXC_VECTOR   (EXC_VEC),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic        wb_en;
        logic        m2r;
        logic [31:0] rdm;
        logic [31:0] alu;
        logic [4:0]  regd;
        logic        sys_en;
        logic        tlb;
        logic [31:0] pc;
        logic [31:0] addr;
        logic        nop;
        logic        iret;
        logic [2:0]  raddr;
    } stim_t;

    int n_vec = 0;
    int n_err = 0;

    // Architectural model: rm file, privilege bit, remaining flush cycles
    // (including the redirect cycle) and the pending redirect target.
    logic [31:0] m_rm [8];
    logic        m_sup;
    int          m_left;
    logic [31:0] m_tgt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic stim_t idle_stim();
        stim_t s;
        s.rst = 1'b0; s.en = 1'b1; s.wb_en = 1'b0; s.m2r = 1'b0;
        s.rdm = 32'd0; s.alu = 32'd0; s.regd = 5'd0; s.sys_en = 1'b0;
        s.tlb = 1'b0; s.pc = 32'd0; s.addr = 32'd0; s.nop = 1'b0;
        s.iret = 1'b0; s.raddr = 3'd0;
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_rm[i] = 32'd0;
        m_sup  = 1'b1;
        m_left = 0;
        m_tgt  = 32'd0;
    endtask

    task automatic drive(input stim_t s);
        reset              = s.rst;
        bus.en             = s.en;
        bus.WB_EN          = s.wb_en;
        bus.MEM_TO_REG     = s.m2r;
        bus.read_data_mem  = s.rdm;
        bus.alu_result     = s.alu;
        bus.regD           = s.regd;
        bus.WB_SYS_EN      = s.sys_en;
        bus.TLB_MISS       = s.tlb;
        bus.PC_TO_REG      = s.pc;
        bus.ADDRESS_TO_REG = s.addr;
        bus.injected_nop   = s.nop;
        bus.iret           = s.iret;
        bus.sys_raddr      = s.raddr;
    endtask

    // One clock cycle: drive after the edge, check mid-cycle, then advance
    // the model to what the next edge should produce.
    task automatic apply(input stim_t s);
        logic        valid;
        logic [31:0] wb;
        logic        exp_we;
        @(posedge clk);
        #1;
        drive(s);
        #1;
        valid  = s.en && !s.nop && (m_left == 0);
        wb     = s.m2r ? s.rdm : s.alu;
        exp_we = !s.rst && valid && !s.tlb && !s.sys_en && !s.iret
                 && s.wb_en && (s.regd != 5'd0);
        check("rf_we", 32'(bus.rf_we), 32'(exp_we));
        if (exp_we) begin
            check("rf_waddr", 32'(bus.rf_waddr), 32'(s.regd));
            check("rf_wdata", bus.rf_wdata, wb);
        end
        check("sys_rdata", bus.sys_rdata, m_rm[s.raddr]);
        check("supervisor", 32'(bus.supervisor_mode), 32'(m_sup));
        check("flush", 32'(bus.flush), 32'(m_left > 0));
        check("pc_redirect", 32'(bus.pc_redirect), 32'(m_left == 1));
        check("pc_target", bus.pc_target, (m_left == 1) ? m_tgt : 32'd0);

        if (s.rst) begin
            model_reset();
        end else if (m_left > 0) begin
            m_left--;
        end else if (valid) begin
            if (s.tlb || ((s.sys_en || s.iret) && !m_sup)) begin
                m_rm[0] = s.pc;
                m_rm[1] = s.tlb ? s.addr : 32'd0;
                m_rm[2] = s.tlb ? 32'd1 : 32'd2;
                m_sup   = 1'b1;
                m_tgt   = EXC_VEC;
                m_left  = FC + 1;
            end else if (s.iret) begin
                m_tgt  = m_rm[0];
                m_sup  = 1'b0;
                m_left = FC + 1;
            end else if (s.sys_en) begin
                m_rm[s.regd[2:0]] = wb;
            end
        end
    endtask

    task automatic idle_cycles(input int n, input logic [2:0] raddr);
        stim_t s;
        s = idle_stim();
        s.raddr = raddr;
        repeat (n) apply(s);
    endtask

    initial begin
        stim_t s;
        int    redirects_seen;

        // Bring the DUT to a known state before the model starts tracking it.
        s = idle_stim();
        s.rst = 1'b1;
        drive(s);
        repeat (2) @(posedge clk);
        model_reset();

        // rf_we stays low while reset is held, even with a write request.
        s.wb_en = 1'b1; s.regd = 5'd5; s.alu = 32'h1234_5678;
        apply(s);

        // GPR writeback from load data, then to r0 (suppressed).
        s = idle_stim();
        s.wb_en = 1'b1; s.m2r = 1'b1; s.rdm = 32'hDEAD_BEEF; s.regd = 5'd5;
        apply(s);
        check("gpr_wdata_const", bus.rf_wdata, 32'hDEAD_BEEF);
        s.regd = 5'd0;
        apply(s);
        check("gpr_r0_const", 32'(bus.rf_we), 32'd0);

        // TLB miss, with a write request in the first flush cycle.
        s = idle_stim();
        s.tlb = 1'b1; s.pc = 32'h0000_1040; s.addr = 32'h8000_0010;
        apply(s);
        s = idle_stim();
        s.wb_en = 1'b1; s.regd = 5'd7; s.alu = 32'h5555_AAAA;
        apply(s);
        idle_cycles(1, 3'd0);
        idle_cycles(1, 3'd1);
        check("tlb_redirect_const", bus.pc_target, EXC_VEC);
        idle_cycles(1, 3'd0);
        check("rm0_const", bus.sys_rdata, 32'h0000_1040);
        idle_cycles(1, 3'd1);
        check("rm1_const", bus.sys_rdata, 32'h8000_0010);
        idle_cycles(1, 3'd2);
        check("rm2_const", bus.sys_rdata, 32'd1);

        // Supervisor iret returns to rm0 and drops to user mode.
        s = idle_stim();
        s.iret = 1'b1;
        apply(s);
        idle_cycles(2, 3'd0);
        idle_cycles(1, 3'd0);
        check("iret_target_const", bus.pc_target, 32'h0000_1040);
        idle_cycles(1, 3'd0);
        check("user_mode_const", 32'(bus.supervisor_mode), 32'd0);

        // Privilege violation: user-mode rm3 write traps.
        s = idle_stim();
        s.sys_en = 1'b1; s.regd = 5'd3; s.alu = 32'd7; s.pc = 32'h0000_3000;
        apply(s);
        idle_cycles(3, 3'd3);
        idle_cycles(1, 3'd3);
        check("rm3_const", bus.sys_rdata, 32'd0);
        idle_cycles(1, 3'd2);
        check("rm2_priv_const", bus.sys_rdata, 32'd2);

        // Supervisor rm write, then bubble and stall versions of a TLB miss.
        s = idle_stim();
        s.sys_en = 1'b1; s.regd = 5'd6; s.m2r = 1'b1; s.rdm = 32'hCAFE_0006;
        apply(s);
        s = idle_stim();
        s.tlb = 1'b1; s.nop = 1'b1; s.pc = 32'h0BAD_0001;
        apply(s);
        s.nop = 1'b0; s.en = 1'b0;
        apply(s);
        idle_cycles(2, 3'd6);
        check("no_flush_const", 32'(bus.flush), 32'd0);

        // Reset in the second flush cycle aborts the redirect.
        s = idle_stim();
        s.tlb = 1'b1; s.pc = 32'h0000_4444; s.addr = 32'h0000_5555;
        apply(s);
        idle_cycles(1, 3'd0);
        s = idle_stim();
        s.rst = 1'b1;
        apply(s);
        redirects_seen = 0;
        for (int i = 0; i < 5; i++) begin
            idle_cycles(1, 3'd0);
            if (bus.pc_redirect) redirects_seen++;
        end
        check("abort_redirects", 32'(redirects_seen), 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            s.rst    = ($urandom_range(0, 299) == 0);
            s.en     = ($urandom_range(0, 7) != 0);
            s.wb_en  = $urandom_range(0, 1) == 1;
            s.m2r    = $urandom_range(0, 1) == 1;
            s.rdm    = $urandom;
            s.alu    = $urandom;
            s.regd   = 5'($urandom_range(0, 31));
            s.sys_en = ($urandom_range(0, 7) == 0);
            s.tlb    = ($urandom_range(0, 19) == 0);
            s.pc     = $urandom;
            s.addr   = $urandom;
            s.nop    = ($urandom_range(0, 7) == 0);
            s.iret   = ($urandom_range(0, 15) == 0);
            s.raddr  = 3'($urandom_range(0, 7));
            apply(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
